// File: rtl/jx2_mem_pc_responder_if.sv
// Instruction-fetch (memPc*) and backing-tile (bk*) signal bundle for jx2_mem_pc_responder.
// slave = responder side, master = core/backing environment side.
interface jx2_mem_pc_responder_if;
    logic [19:0]  memPcAddr;
    logic         memPcOE;
    logic [255:0] memPcData;
    logic [1:0]   memPcOK;
    logic [19:0]  bkAddr;
    logic         bkOE;
    logic [127:0] bkData;
    logic [1:0]   bkOK;

    modport slave (
        input  memPcAddr, memPcOE, bkData, bkOK,
        output memPcData, memPcOK, bkAddr, bkOE
    );

    modport master (
        output memPcAddr, memPcOE, bkData, bkOK,
        input  memPcData, memPcOK, bkAddr, bkOE
    );
endinterface

// File: rtl/jx2_mem_pc_responder.sv
// 256-bit fetch responder: two 128-bit backing beats (addr, addr+16) merged into one line.
// Optional one-entry line buffer enabled by defining JX2_MEMPC_LINEBUF_EN.
module jx2_mem_pc_responder #(
    parameter logic [7:0] BK_TIMEOUT = 8'd255
) (
    input  logic                   clock,
    input  logic                   reset,
    jx2_mem_pc_responder_if.slave  bus
);
    typedef enum logic [1:0] {
        UMEM_READY = 2'b00,
        UMEM_OK    = 2'b01,
        UMEM_HOLD  = 2'b10,
        UMEM_FAULT = 2'b11
    } umem_t;

    typedef enum logic [2:0] {
        IDLE, REQ_LO, GAP, REQ_HI, DONE, ERR
    } state_t;

    state_t         state;
    logic [15:0]    tile_a;
    logic [127:0]   lo_tile;
    logic [255:0]   data_q;
    logic [1:0]     ok_q;
    logic [19:0]    bk_addr_q;
    logic           bk_oe_q;
    logic [7:0]     tcnt;
    logic           restart;
    logic [15:0]    req_tile;
    logic           bk_ok;
    logic           beat_fail;
`ifdef JX2_MEMPC_LINEBUF_EN
    logic [255:0]   lb_data;
    logic [15:0]    lb_tag;
    logic           lb_valid;
`endif

    assign req_tile  = bus.memPcAddr[19:4];
    assign bk_ok     = (bus.bkOK == UMEM_OK);
    assign beat_fail = (bus.bkOK == UMEM_FAULT) || (!bk_ok && tcnt == BK_TIMEOUT);

    assign bus.memPcData = data_q;
    assign bus.memPcOK   = ok_q;
    assign bus.bkAddr    = bk_addr_q;
    assign bus.bkOE      = bk_oe_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tile_a    <= '0;
            lo_tile   <= '0;
            data_q    <= '0;
            ok_q      <= UMEM_READY;
            bk_addr_q <= '0;
            bk_oe_q   <= 1'b0;
            tcnt      <= '0;
            restart   <= 1'b0;
`ifdef JX2_MEMPC_LINEBUF_EN
            lb_data   <= '0;
            lb_tag    <= '0;
            lb_valid  <= 1'b0;
`endif
        end else begin
            case (state)
                // DONE with a new address behaves exactly like an IDLE request.
                IDLE, DONE: begin
                    if (!bus.memPcOE) begin
                        ok_q  <= UMEM_READY;
                        state <= IDLE;
                    end else if (state == DONE && req_tile == tile_a) begin
                        ok_q <= UMEM_OK;
`ifdef JX2_MEMPC_LINEBUF_EN
                    end else if (lb_valid && lb_tag == req_tile) begin
                        tile_a <= req_tile;
                        data_q <= lb_data;
                        ok_q   <= UMEM_OK;
                        state  <= DONE;
`endif
                    end else begin
                        tile_a    <= req_tile;
                        bk_addr_q <= {req_tile, 4'h0};
                        bk_oe_q   <= 1'b1;
                        ok_q      <= UMEM_HOLD;
                        tcnt      <= '0;
                        restart   <= 1'b0;
                        state     <= REQ_LO;
                    end
                end
                REQ_LO, REQ_HI: begin
                    if (beat_fail) begin
                        bk_oe_q <= 1'b0;
                        ok_q    <= UMEM_FAULT;
`ifdef JX2_MEMPC_LINEBUF_EN
                        lb_valid <= 1'b0;
`endif
                        state   <= ERR;
                    end else if (!bk_ok) begin
                        tcnt <= tcnt + 8'd1;
                    end else begin
                        bk_oe_q <= 1'b0;
                        if (!bus.memPcOE) begin
                            ok_q  <= UMEM_READY;
                            state <= IDLE;
                        end else if (req_tile != tile_a) begin
                            // Restart goes via GAP so the backing bus idles before the new beat.
                            tile_a  <= req_tile;
                            restart <= 1'b1;
                            state   <= GAP;
                        end else if (state == REQ_LO) begin
                            lo_tile <= bus.bkData;
                            state   <= GAP;
                        end else begin
                            data_q <= {bus.bkData, lo_tile};
                            ok_q   <= UMEM_OK;
`ifdef JX2_MEMPC_LINEBUF_EN
                            lb_data  <= {bus.bkData, lo_tile};
                            lb_tag   <= tile_a;
                            lb_valid <= 1'b1;
`endif
                            state  <= DONE;
                        end
                    end
                end
                GAP: begin
                    if (!bus.memPcOE) begin
                        ok_q  <= UMEM_READY;
                        state <= IDLE;
                    end else if (req_tile != tile_a) begin
                        tile_a  <= req_tile;
                        restart <= 1'b1;
                    end else if (!bk_ok) begin
                        bk_oe_q <= 1'b1;
                        tcnt    <= '0;
                        if (restart) begin
                            bk_addr_q <= {tile_a, 4'h0};
                            restart   <= 1'b0;
                            state     <= REQ_LO;
                        end else begin
                            bk_addr_q <= {tile_a + 16'h0001, 4'h0};
                            state     <= REQ_HI;
                        end
                    end
                end
                ERR: begin
                    if (!bus.memPcOE) begin
                        ok_q  <= UMEM_READY;
                        state <= IDLE;
                    end
                end
                default: begin
                    bk_oe_q <= 1'b0;
                    ok_q    <= UMEM_READY;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jx2_mem_pc_responder.sv
// Directed bench for jx2_mem_pc_responder with a small backing-bus responder model.
// Backing modes: 0 zero-wait, 1 FAULT on tile 16'h0346, 2 never answers.
module tb_jx2_mem_pc_responder;
    localparam logic [1:0] READY = 2'b00;
    localparam logic [1:0] OK    = 2'b01;
    localparam logic [1:0] HOLD  = 2'b10;
    localparam logic [1:0] FAULT = 2'b11;

    logic        clock;
    logic        reset;
    int unsigned checks;
    int unsigned failures;
    int unsigned bk_mode;
    logic        bk_oe_d;

    jx2_mem_pc_responder_if bus ();

    jx2_mem_pc_responder #(.BK_TIMEOUT(8'd255)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [127:0] tile(input logic [15:0] t);
        return {t, 16'hA5A5, ~t, 16'h0F0F, t ^ 16'h1234, 16'hBEEF, t + 16'h0001, 16'hC0DE};
    endfunction

    // Backing keeps OK for one clock after bkOE drops, then returns READY.
    always @(posedge clock or negedge reset) begin
        if (!reset) bk_oe_d <= 1'b0;
        else        bk_oe_d <= bus.bkOE;
    end

    always_comb begin
        bus.bkData = tile(bus.bkAddr[19:4]);
        bus.bkOK   = (bus.bkOE || bk_oe_d) ? OK : READY;
        if (bk_mode == 1 && bus.bkOE && bus.bkAddr[19:4] == 16'h0346) bus.bkOK = FAULT;
        if (bk_mode == 2) bus.bkOK = READY;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ok(input int unsigned budget, input string tag);
        for (int unsigned i = 0; i < budget && bus.memPcOK !== OK; i++) tick();
        check(tag, {254'd0, bus.memPcOK}, {254'd0, OK});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        bk_mode  = 0;
        reset    = 1'b1;
        bus.memPcOE   = 1'b0;
        bus.memPcAddr = '0;
        #2 reset = 1'b0;
        #1;
        check("rst_ok",    bus.memPcOK, READY);
        check("rst_data",  bus.memPcData, '0);
        check("rst_bkoe",  bus.bkOE, 1'b0);
        check("rst_bkadr", bus.bkAddr, 20'h00000);
        tick();
        tick();
        #2 reset = 1'b1;
        tick();
        check("idle_ready", bus.memPcOK, READY);

        // 1: basic fetch, OK four clocks after the sampling edge
        bus.memPcAddr = 20'h01230;
        bus.memPcOE   = 1'b1;
        tick();
        check("t1_lo_addr", bus.bkAddr, 20'h01230);
        check("t1_lo_oe",   bus.bkOE, 1'b1);
        check("t1_hold",    bus.memPcOK, HOLD);
        tick();
        check("t1_lo_drop", bus.bkOE, 1'b0);
        tick();
        check("t1_gap_wait", bus.bkOE, 1'b0);
        tick();
        check("t1_hi_addr", bus.bkAddr, 20'h01240);
        check("t1_hi_oe",   bus.bkOE, 1'b1);
        check("t1_hold3",   bus.memPcOK, HOLD);
        tick();
        check("t1_ok_at4",  bus.memPcOK, OK);
        check("t1_data",    bus.memPcData, {tile(16'h0124), tile(16'h0123)});
        check("t1_hi_drop", bus.bkOE, 1'b0);
        tick();
        check("t1_done_hold", bus.memPcOK, OK);

        // 5: new address while DONE with OE held
        bus.memPcAddr = 20'h01250;
        tick();
        check("t5_hold",    bus.memPcOK, HOLD);
        check("t5_bkaddr",  bus.bkAddr, 20'h01250);
        wait_ok(12, "t5_ok");
        check("t5_data",    bus.memPcData, {tile(16'h0126), tile(16'h0125)});
        bus.memPcOE = 1'b0;
        tick();
        check("t5_ready",   bus.memPcOK, READY);
        bus.memPcOE = 1'b1;
        tick();
`ifdef JX2_MEMPC_LINEBUF_EN
        check("t5_lb_ok",   bus.memPcOK, OK);
        check("t5_lb_bkoe", bus.bkOE, 1'b0);
        check("t5_lb_data", bus.memPcData, {tile(16'h0126), tile(16'h0125)});
`else
        check("t5_re_hold", bus.memPcOK, HOLD);
        check("t5_re_bkoe", bus.bkOE, 1'b1);
        wait_ok(12, "t5_re_ok");
        check("t5_re_data", bus.memPcData, {tile(16'h0126), tile(16'h0125)});
`endif
        bus.memPcOE = 1'b0;
        tick();

        // 2: tile address wraps
        bus.memPcAddr = 20'hFFFF0;
        bus.memPcOE   = 1'b1;
        tick();
        check("t2_lo_addr", bus.bkAddr, 20'hFFFF0);
        tick();
        tick();
        tick();
        check("t2_hi_addr", bus.bkAddr, 20'h00000);
        tick();
        check("t2_ok",   bus.memPcOK, OK);
        check("t2_data", bus.memPcData, {tile(16'h0000), tile(16'hFFFF)});
        bus.memPcOE = 1'b0;
        tick();

        // 3a: FAULT on hi beat
        bk_mode = 1;
        bus.memPcAddr = 20'h03450;
        bus.memPcOE   = 1'b1;
        tick();
        tick();
        tick();
        tick();
        check("t3_hi_oe", bus.bkOE, 1'b1);
        tick();
        check("t3_fault",  bus.memPcOK, FAULT);
        check("t3_f_bkoe", bus.bkOE, 1'b0);
        tick();
        tick();
        check("t3_fault_held", bus.memPcOK, FAULT);
        bus.memPcOE = 1'b0;
        tick();
        check("t3_ready", bus.memPcOK, READY);

        // 3b: backing never answers
        bk_mode = 2;
        bus.memPcAddr = 20'h05670;
        bus.memPcOE   = 1'b1;
        tick();
        for (int i = 0; i < 255; i++) tick();
        check("t3_to_hold", bus.memPcOK, HOLD);
        check("t3_to_bkoe", bus.bkOE, 1'b1);
        tick();
        check("t3_to_fault", bus.memPcOK, FAULT);
        check("t3_to_drop",  bus.bkOE, 1'b0);
        bus.memPcOE = 1'b0;
        tick();
        check("t3_to_ready", bus.memPcOK, READY);
        bk_mode = 0;

        // 4: asynchronous reset while in REQ_HI
        bus.memPcAddr = 20'h07890;
        bus.memPcOE   = 1'b1;
        tick();
        tick();
        tick();
        tick();
        check("t4_in_hi", bus.bkOE, 1'b1);
        #1 reset = 1'b0;
        #1;
        check("t4_rst_bkoe", bus.bkOE, 1'b0);
        check("t4_rst_ok",   bus.memPcOK, READY);
        check("t4_rst_data", bus.memPcData, '0);
        bus.memPcOE = 1'b0;
        tick();
        #2 reset = 1'b1;
        bus.memPcAddr = 20'h089A0;
        bus.memPcOE   = 1'b1;
        tick();
        check("t4_new_hold", bus.memPcOK, HOLD);
        wait_ok(12, "t4_new_ok");
        check("t4_new_data", bus.memPcData, {tile(16'h089B), tile(16'h089A)});
        bus.memPcOE = 1'b0;
        tick();
        check("t4_ready", bus.memPcOK, READY);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
